// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// opcode constants used to build the bubble word, and PC arithmetic helpers.
// -----------------------------------------------------------------------------
package fetch_pkg;

    // Fetch FSM states (2-bit encoding).
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    // Opcode field lives in instr[15:11].
    localparam logic [4:0]  OPC_NOP  = 5'b00001;
    localparam logic [4:0]  OPC_HALT = 5'b00000;

    localparam logic [15:0] PC_STEP  = 16'd2;

    // Next sequential PC; wraps modulo 2^16 with no fault.
    function automatic logic [15:0] pc_inc(input logic [15:0] pc);
        return pc + PC_STEP;
    endfunction

    // Instructions are halfword aligned; bit 0 set means a fault.
    function automatic logic is_misaligned(input logic [15:0] pc);
        return pc[0];
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// -----------------------------------------------------------------------------
// fetch_hold_buf
// Single-entry buffer that parks a fetched word (and its PC+2) while decode is
// stalled, so the memory transaction can retire without losing the word.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   load              capture load_instr/load_pc_plus2, mark entry full
//   present           entry is being handed to the output registers; empty it
//   drop              discard the entry (redirect/halt); wins over load
//   load_instr        word to capture
//   load_pc_plus2     PC+2 of the word to capture
//   buf_instr         buffered word
//   buf_pc_plus2      buffered PC+2
//   buf_valid         entry holds a real instruction
// -----------------------------------------------------------------------------
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        present,
    input  logic        drop,
    input  logic [15:0] load_instr,
    input  logic [15:0] load_pc_plus2,
    output logic [15:0] buf_instr,
    output logic [15:0] buf_pc_plus2,
    output logic        buf_valid
);

    logic [15:0] instr_r;
    logic [15:0] pc_plus2_r;
    logic        valid_r;

    // Entry storage: drop beats load, load beats present.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_r    <= {OPC_NOP, 11'd0};
            pc_plus2_r <= 16'd0;
            valid_r    <= 1'b0;
        end else if (drop) begin
            valid_r    <= 1'b0;
        end else if (load) begin
            instr_r    <= load_instr;
            pc_plus2_r <= load_pc_plus2;
            valid_r    <= 1'b1;
        end else if (present) begin
            valid_r    <= 1'b0;
        end else begin
            valid_r    <= valid_r;
        end
    end

    assign buf_instr    = instr_r;
    assign buf_pc_plus2 = pc_plus2_r;
    assign buf_valid    = valid_r;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, runs a req/done handshake with a
// variable-latency instruction memory and feeds decode through registered
// outputs. Handles decode stall (hold buffer), redirect with squash of the
// in-flight request, misaligned-PC fault and halt.
//
// Optional build macro: FETCH_STALL_CNT_EN adds output stallCycles, a
// saturating count of cycles with imem_req=1 and imem_done=0.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   stall        decode cannot accept; hold outputs
//   redirect     taken branch/jump resolved downstream
//   redirectPC   redirect target
//   haltReq      HALT committed downstream
//   imem_req     fetch request (registered)
//   imem_addr    fetch address, stable while imem_req=1 (registered)
//   imem_rdata   returned word, valid with imem_done
//   imem_done    one-cycle completion pulse
//   instr        instruction to decode (NOP_INSTR when valid=0)
//   pcPlus2      PC of instr + 2
//   valid        instr is real
//   align_err_i  slot carries a misaligned-fetch fault
//   halted       fetch permanently stopped
//   stallCycles  (FETCH_STALL_CNT_EN only) memory wait-cycle counter
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = {OPC_NOP, 11'd0}
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirectPC,
    input  logic        haltReq,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    output logic [15:0] instr,
    output logic [15:0] pcPlus2,
    output logic        valid,
    output logic        align_err_i,
    output logic        halted
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0] stallCycles
`endif
);

    fetch_state_t state_r, state_nx;
    logic [15:0]  pc_r, pc_nx;
    logic         halt_pend_r, halt_pend_nx;
    logic         req_r, req_nx_s;
    logic [15:0]  addr_r, addr_nx_s;
    logic         halted_r;

    logic [15:0]  instr_r, pc_plus2_r;
    logic         valid_r, align_err_r;

    logic         out_upd_s, out_valid_s, out_aerr_s;
    logic [15:0]  out_instr_s, out_pc_plus2_s;

    logic         buf_load_s, buf_present_s, buf_drop_s;
    logic [15:0]  buf_instr_s, buf_pc_plus2_s;
    logic         buf_valid_s;

    logic         done_s, outstanding_s;

    // A completion only counts against a request we actually issued.
    assign done_s        = req_r & imem_done;
    assign outstanding_s = req_r & ~imem_done;

    fetch_hold_buf u_hold_buf (
        .clk           (clk),
        .rst           (rst),
        .load          (buf_load_s),
        .present       (buf_present_s),
        .drop          (buf_drop_s),
        .load_instr    (imem_rdata),
        .load_pc_plus2 (pc_inc(pc_r)),
        .buf_instr     (buf_instr_s),
        .buf_pc_plus2  (buf_pc_plus2_s),
        .buf_valid     (buf_valid_s)
    );

    // Next-state, next-PC, hold-buffer controls and output-register values.
    always_comb begin
        state_nx       = state_r;
        pc_nx          = pc_r;
        halt_pend_nx   = halt_pend_r;
        buf_load_s     = 1'b0;
        buf_present_s  = 1'b0;
        buf_drop_s     = 1'b0;
        // Outputs freeze under stall, otherwise fall back to a bubble.
        out_upd_s      = ~stall;
        out_instr_s    = NOP_INSTR;
        out_pc_plus2_s = pc_plus2_r;
        out_valid_s    = 1'b0;
        out_aerr_s     = 1'b0;

        case (state_r)
            ST_FETCH: begin
                if (haltReq) begin
                    out_upd_s = 1'b1;
                    // Let an in-flight request finish before going quiet.
                    if (outstanding_s) begin
                        state_nx     = ST_SQUASH;
                        halt_pend_nx = 1'b1;
                    end else begin
                        state_nx     = ST_HALTED;
                    end
                end else if (redirect) begin
                    out_upd_s = 1'b1;
                    pc_nx     = redirectPC;
                    if (outstanding_s) begin
                        state_nx = ST_SQUASH;
                    end else begin
                        state_nx = ST_FETCH;
                    end
                end else if (is_misaligned(pc_r)) begin
                    // No request was issued; emit the fault slot once decode takes it.
                    if (!stall) begin
                        out_valid_s    = 1'b1;
                        out_aerr_s     = 1'b1;
                        out_pc_plus2_s = pc_inc(pc_r);
                        state_nx       = ST_HALTED;
                    end else begin
                        state_nx       = ST_FETCH;
                    end
                end else if (done_s) begin
                    pc_nx = pc_inc(pc_r);
                    if (!stall) begin
                        out_instr_s    = imem_rdata;
                        out_pc_plus2_s = pc_inc(pc_r);
                        out_valid_s    = 1'b1;
                        state_nx       = ST_FETCH;
                    end else begin
                        buf_load_s     = 1'b1;
                        state_nx       = ST_HOLD;
                    end
                end else begin
                    state_nx = ST_FETCH;
                end
            end

            ST_SQUASH: begin
                // The old request is still on the bus; its word is thrown away.
                if (haltReq || halt_pend_r) begin
                    halt_pend_nx = 1'b1;
                    out_upd_s    = 1'b1;
                end else if (redirect) begin
                    pc_nx        = redirectPC;
                    out_upd_s    = 1'b1;
                end else begin
                    halt_pend_nx = 1'b0;
                end
                if (done_s) begin
                    state_nx = (haltReq || halt_pend_r) ? ST_HALTED : ST_FETCH;
                end else begin
                    state_nx = ST_SQUASH;
                end
            end

            ST_HOLD: begin
                if (haltReq) begin
                    buf_drop_s = 1'b1;
                    out_upd_s  = 1'b1;
                    state_nx   = ST_HALTED;
                end else if (redirect) begin
                    buf_drop_s = 1'b1;
                    out_upd_s  = 1'b1;
                    pc_nx      = redirectPC;
                    state_nx   = ST_FETCH;
                end else if (!stall) begin
                    buf_present_s  = 1'b1;
                    out_instr_s    = buf_instr_s;
                    out_pc_plus2_s = buf_pc_plus2_s;
                    out_valid_s    = buf_valid_s;
                    state_nx       = ST_FETCH;
                end else begin
                    state_nx = ST_HOLD;
                end
            end

            ST_HALTED: begin
                out_upd_s = 1'b1;
                state_nx  = ST_HALTED;
            end

            default: begin
                state_nx = ST_FETCH;
            end
        endcase
    end

    // Request is a function of where we land next; SQUASH keeps the old address.
    assign req_nx_s  = ((state_nx == ST_FETCH) && !is_misaligned(pc_nx)) ||
                       (state_nx == ST_SQUASH);
    assign addr_nx_s = (state_nx == ST_SQUASH) ? addr_r : pc_nx;

    // FSM, PC and memory-interface registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_FETCH;
            pc_r        <= RESET_PC;
            halt_pend_r <= 1'b0;
            req_r       <= 1'b0;
            addr_r      <= RESET_PC;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_nx;
            pc_r        <= pc_nx;
            halt_pend_r <= halt_pend_nx;
            req_r       <= req_nx_s;
            addr_r      <= addr_nx_s;
            halted_r    <= (state_nx == ST_HALTED);
        end
    end

    // Decode-facing output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_r     <= NOP_INSTR;
            pc_plus2_r  <= pc_inc(RESET_PC);
            valid_r     <= 1'b0;
            align_err_r <= 1'b0;
        end else if (out_upd_s) begin
            instr_r     <= out_instr_s;
            pc_plus2_r  <= out_pc_plus2_s;
            valid_r     <= out_valid_s;
            align_err_r <= out_aerr_s;
        end else begin
            valid_r     <= valid_r;
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = addr_r;
    assign instr       = instr_r;
    assign pcPlus2     = pc_plus2_r;
    assign valid       = valid_r;
    assign align_err_i = align_err_r;
    assign halted      = halted_r;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Memory wait-cycle counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= 16'd0;
        end else if (req_r && !imem_done && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stallCycles = stall_cnt_r;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline; producer of the instruction stream that decode consumes (instr, pcPlus2, valid, align_err_i).
- Owns the PC and runs a req/done handshake with a variable-latency instruction memory (cache or stall memory).
- Handles downstream stall, branch/jump redirect with squash of in-flight fetches, misaligned PC, and halt.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, instruction word driven whenever valid=0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- stall  in  1  hazard unit: decode cannot accept; hold outputs.
- redirect  in  1  taken branch/jump/JR resolved downstream.
- redirectPC  in  16  target PC, sampled when redirect=1.
- haltReq  in  1  HALT committed downstream; stop fetching.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  16  fetch address; stable while imem_req=1.
- imem_rdata  in  16  instruction word, valid when imem_done=1.
- imem_done  in  1  one-cycle completion pulse.
- instr  out  16  instruction to decode.
- pcPlus2  out  16  PC of instr + 2.
- valid  out  1  instr is a real instruction.
- align_err_i  out  1  instr slot carries a misaligned-fetch fault.
- halted  out  1  fetch permanently stopped.

Behaviour:
- Reset values: PC=RESET_PC, instr=NOP_INSTR, pcPlus2=RESET_PC+2, valid=0, align_err_i=0, imem_req=0, halted=0, state=FETCH. Reset mid-transaction abandons any request; the memory is reset by the same rst.
- Memory handshake:
  - imem_req=1 and imem_addr=PC are held until imem_done.
  - imem_done may assert in the same cycle as imem_req (zero-wait hit) or in any later cycle.
  - A new request is not issued in the cycle done is seen; the next request starts the following cycle.
- States:
  - FETCH: req asserted.
    - done with no redirect: if stall=0, load output regs (instr=imem_rdata, valid=1, pcPlus2=PC+2), PC<=PC+2, stay in FETCH. If stall=1, capture the word in the hold buffer, PC<=PC+2, go to HOLD.
    - redirect without done: go to SQUASH, PC<=redirectPC.
    - redirect with done: drop the word, PC<=redirectPC, stay in FETCH.
  - SQUASH: req held on the old address. Returned word is discarded. On done, go to FETCH and issue the new PC next cycle.
  - HOLD: req=0. When stall=0, present the buffer (valid=1) and go to FETCH. If redirect is seen, the buffer is dropped and the stage goes to FETCH with PC=redirectPC.
  - HALTED: req=0, valid=0, halted=1. Exit only via reset.
- Output registers:
  - Update only when stall=0.
  - Absent a completing fetch, drive a bubble (valid=0, instr=NOP_INSTR).
  - redirect has priority over stall: the next cycle shows valid=0 regardless of stall.
- Misaligned PC (PC[0]=1) in FETCH:
  - No memory request is issued.
  - When stall=0, emit one slot with valid=1, align_err_i=1, instr=NOP_INSTR (decode forces opcode 00000, i.e. HALT), then enter HALTED.
  - A redirect arriving in the same cycle takes priority over the fault.
- haltReq:
  - In FETCH with no outstanding done, go to SQUASH-then-HALTED so the request completes cleanly.
  - Otherwise go directly to HALTED; valid=0 from the next cycle.
- Arithmetic: PC+2 wraps modulo 2^16 (16'hFFFE -> 16'h0000). No wrap fault is raised.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- Defined: adds output stallCycles[15:0], counting cycles where imem_req=1 && imem_done=0. It saturates at 16'hFFFF and resets to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg:
  - state encoding (FETCH, SQUASH, HOLD, HALTED, 2 bits);
  - NOP opcode constant 5'b00001;
  - HALT opcode constant 5'b00000.
- One natural sub-module, fetch_hold_buf: a single-entry instr/pcPlus2 register with load/present/drop controls.
- PC register and FSM stay in the top module.

Test Plan:
- Zero-wait memory, no stalls, reset at 0: instrs at 0,2,4 appear back-to-back with valid=1 and pcPlus2=2,4,6; imem_addr advances by 2 each cycle.
- 3-cycle memory latency: imem_addr holds 16'h0000 for 3 cycles with req=1; valid pulses once per fetch with bubbles between; stallCycles=2 per fetch when FETCH_STALL_CNT_EN is defined.
- stall=1 for 4 cycles while done arrives: word is buffered (HOLD, req=0), outputs frozen; on release the buffered word appears once, no duplicate and no loss.
- redirect to 16'h0040 during a pending 3-cycle fetch of 16'h0010: req held on 0x0010 until done, that word is never shown as valid, next imem_addr=0x0040.
- redirect to 16'h0041: no request issued; one slot with valid=1, align_err_i=1, instr=16'h0800; then halted=1 and req stays 0 for the next 20 cycles despite a later redirect.
- haltReq mid-fetch, then rst low asynchronously mid-SQUASH: outputs return immediately to reset values; after release, fetch restarts at RESET_PC.
